// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, opcode/funct codes
// and the fetch-queue entry type.
package cpu_pkg;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fq_entry_t;

    function automatic logic [5:0] op_of(input logic [31:0] w);
        return w[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [5:0] funct_of(input logic [31:0] w);
        return w[FUNCT_MSB:FUNCT_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch unit bus: instruction-memory read port plus the
// decoder-side valid/ready stream and redirect path.
interface instr_fetch_if;

    logic        im_en;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [5:0]  OP;
    logic [5:0]  funct;

    modport master (
        output im_en, im_addr,
        input  im_rdata,
        input  redirect, redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr, instr_pc, OP, funct
    );

    modport slave (
        input  im_en, im_addr,
        output im_rdata,
        output redirect, redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr, instr_pc, OP, funct
    );

endinterface

// File: rtl/fetch_fifo.sv
// Fetch queue: DEPTH-entry synchronous FIFO of {instr, pc},
// first-word-fall-through head, flush empties it in one cycle.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  fq_entry_t                data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fq_entry_t                data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    fq_entry_t     mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign do_pop  = pop_i & (cnt_q != '0);
    assign do_push = push_i & ~flush_i;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push & ~rst) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: PC, memory read issue, stale-response
// tracking and the decoder-facing queue.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0] pc_q, pc_d;
    logic [31:0] tag_q, tag_d;
    logic        inflight_q, inflight_d;
    logic        stale_q, stale_d;

    logic [CW-1:0] count;
    logic [CW:0]   occ;
    fq_entry_t     head, wdata;
    logic          valid, pop, push, issue;

    assign valid = (count != '0);
    assign pop   = valid & bus.instr_ready;

    // Issue only if the reply still fits after this cycle's pop.
    assign occ   = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue = ~rst & ~bus.redirect & (occ < (CW+1)'(DEPTH));
    assign push  = inflight_q & ~stale_q & ~bus.redirect & ~rst;
    assign wdata = '{instr: bus.im_rdata, pc: tag_q};

    always_comb begin
        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = 1'b0;
        stale_d    = 1'b0;
        if (bus.redirect) begin
            pc_d    = bus.redirect_pc & ~32'h3;
            stale_d = inflight_q;
        end else if (issue) begin
            pc_d       = pc_q + 32'd4;
            tag_d      = pc_q;
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            stale_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            stale_q    <= stale_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (wdata),
        .pop_i   (pop),
        .flush_i (bus.redirect),
        .data_o  (head),
        .count_o (count)
    );

    assign bus.im_en       = issue;
    assign bus.im_addr     = pc_q;
    assign bus.instr_valid = valid;
    assign bus.instr       = valid ? head.instr : '0;
    assign bus.instr_pc    = valid ? head.pc : '0;
    assign bus.OP          = op_of(bus.instr);
    assign bus.funct       = funct_of(bus.instr);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector table plus
// redirect/pop and reset/wrap sequences.
module tb_instr_fetch;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst0 = 1'b1;
    logic rst1 = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    instr_fetch_if b0 ();
    instr_fetch_if b1 ();

    instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) u0 (
        .clk (clk), .rst (rst0), .bus (b0.master));

    instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u1 (
        .clk (clk), .rst (rst1), .bus (b1.master));

    function automatic logic [31:0] memval(input logic [31:0] a);
        case (a)
            32'h200: return 32'h0000_0020;
            32'h204: return 32'h8C00_0000;
            32'h208: return 32'hAC00_0000;
            default: return a << 1;
        endcase
    endfunction

    always @(posedge clk) begin
        if (b0.im_en) b0.im_rdata <= memval(b0.im_addr);
        if (b1.im_en) b1.im_rdata <= memval(b1.im_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          rdr;
        logic [31:0] rpc;
        bit          on;
        bit          en;
        logic [31:0] addr;
        bit          v;
        logic [31:0] pc;
        logic [31:0] ins;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(bit r, bit rdy, bit rdr, logic [31:0] rpc,
                               bit on, bit en, logic [31:0] addr, bit v,
                               logic [31:0] pc, logic [31:0] ins);
        vec_t t;
        t = '{r, rdy, rdr, rpc, on, en, addr, v, pc, ins};
        return t;
    endfunction

    logic [31:0] acc[$];
    logic [31:0] exp_acc[8];
    logic [31:0] w_addr[7];
    bit          w_v[7];
    logic [31:0] w_pc[7];
    bit          w_en[7];

    initial begin
        b0.instr_ready = 1'b0;
        b0.redirect    = 1'b0;
        b0.redirect_pc = '0;
        b1.instr_ready = 1'b0;
        b1.redirect    = 1'b0;
        b1.redirect_pc = '0;

        // reset, free-running stream
        tbl.push_back(V(1,0,0,0,     1,0,32'h00, 0,0,0));
        tbl.push_back(V(0,1,0,0,     1,1,32'h00, 0,0,0));
        tbl.push_back(V(0,1,0,0,     1,1,32'h04, 0,0,0));
        tbl.push_back(V(0,1,0,0,     1,1,32'h08, 1,32'h0,32'h00));
        tbl.push_back(V(0,1,0,0,     1,1,32'h0C, 1,32'h4,32'h08));
        tbl.push_back(V(0,1,0,0,     1,1,32'h10, 1,32'h8,32'h10));
        tbl.push_back(V(1,0,0,0,     1,0,32'h14, 1,32'hC,32'h18));
        // stall until full, then drain
        tbl.push_back(V(1,0,0,0,     1,0,32'h00, 0,0,0));
        tbl.push_back(V(0,0,0,0,     1,1,32'h00, 0,0,0));
        tbl.push_back(V(0,0,0,0,     1,1,32'h04, 0,0,0));
        tbl.push_back(V(0,0,0,0,     1,1,32'h08, 1,32'h0,32'h0));
        tbl.push_back(V(0,0,0,0,     1,1,32'h0C, 1,32'h0,32'h0));
        tbl.push_back(V(0,0,0,0,     1,0,32'h10, 1,32'h0,32'h0));
        tbl.push_back(V(0,0,0,0,     1,0,32'h10, 1,32'h0,32'h0));
        tbl.push_back(V(0,0,0,0,     1,0,32'h10, 1,32'h0,32'h0));
        tbl.push_back(V(0,1,0,0,     1,1,32'h10, 1,32'h0,32'h0));
        tbl.push_back(V(0,1,0,0,     1,1,32'h14, 1,32'h4,32'h08));
        tbl.push_back(V(0,1,0,0,     1,1,32'h18, 1,32'h8,32'h10));
        tbl.push_back(V(0,1,0,0,     1,1,32'h1C, 1,32'hC,32'h18));
        tbl.push_back(V(0,1,0,0,     1,1,32'h20, 1,32'h10,32'h20));
        tbl.push_back(V(0,1,0,0,     1,1,32'h24, 1,32'h14,32'h28));
        // redirect with 2 queued and 0x10 in flight
        tbl.push_back(V(1,0,0,0,     0,0,0,      0,0,0));
        tbl.push_back(V(1,0,0,0,     1,0,32'h00, 0,0,0));
        tbl.push_back(V(0,0,0,0,     1,1,32'h00, 0,0,0));
        tbl.push_back(V(0,0,0,0,     1,1,32'h04, 0,0,0));
        tbl.push_back(V(0,0,0,0,     1,1,32'h08, 1,32'h0,32'h0));
        tbl.push_back(V(0,1,0,0,     1,1,32'h0C, 1,32'h0,32'h0));
        tbl.push_back(V(0,1,0,0,     1,1,32'h10, 1,32'h4,32'h08));
        tbl.push_back(V(0,0,1,32'h103, 1,0,32'h14, 1,32'h8,32'h10));
        tbl.push_back(V(0,0,0,0,     1,1,32'h100, 0,0,0));
        tbl.push_back(V(0,0,0,0,     1,1,32'h104, 0,0,0));
        tbl.push_back(V(0,1,0,0,     1,1,32'h108, 1,32'h100,32'h200));
        tbl.push_back(V(0,1,0,0,     1,1,32'h10C, 1,32'h104,32'h208));
        // decoder field stream
        tbl.push_back(V(0,0,1,32'h200, 1,0,32'h110, 1,32'h108,32'h210));
        tbl.push_back(V(0,0,0,0,     1,1,32'h200, 0,0,0));
        tbl.push_back(V(0,0,0,0,     1,1,32'h204, 0,0,0));
        tbl.push_back(V(0,1,0,0,     1,1,32'h208, 1,32'h200,32'h0000_0020));
        tbl.push_back(V(0,1,0,0,     1,1,32'h20C, 1,32'h204,32'h8C00_0000));
        tbl.push_back(V(0,1,0,0,     1,1,32'h210, 1,32'h208,32'hAC00_0000));

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            rst0           = tbl[i].rst;
            b0.instr_ready = tbl[i].rdy;
            b0.redirect    = tbl[i].rdr;
            b0.redirect_pc = tbl[i].rpc;
            @(negedge clk);
            if (tbl[i].on) begin
                chk($sformatf("r%0d im_en", i), 32'(b0.im_en), 32'(tbl[i].en));
                chk($sformatf("r%0d im_addr", i), b0.im_addr, tbl[i].addr);
                chk($sformatf("r%0d valid", i), 32'(b0.instr_valid),
                    32'(tbl[i].v));
                if (tbl[i].v || tbl[i].rst) begin
                    chk($sformatf("r%0d instr_pc", i), b0.instr_pc, tbl[i].pc);
                    chk($sformatf("r%0d instr", i), b0.instr, tbl[i].ins);
                    chk($sformatf("r%0d OP", i), 32'(b0.OP),
                        32'(tbl[i].ins[31:26]));
                    chk($sformatf("r%0d funct", i), 32'(b0.funct),
                        32'(tbl[i].ins[5:0]));
                end
            end
            @(posedge clk);
            #1;
        end
        chk("rtype OP const", 32'(op_of(32'h0000_0020)), 32'(OP_RTYPE));
        chk("add funct const", 32'(funct_of(32'h0000_0020)), 32'(FN_ADD));

        // redirect coincident with pop of 0x8
        b0.redirect    = 1'b0;
        b0.instr_ready = 1'b1;
        rst0 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            b0.redirect    = (c == 4);
            b0.redirect_pc = 32'h300;
            @(negedge clk);
            if (b0.instr_valid && b0.instr_ready) begin
                acc.push_back(b0.instr_pc);
                chk($sformatf("rp c%0d data", c), b0.instr,
                    memval(b0.instr_pc));
            end
            @(posedge clk);
            #1;
        end
        b0.redirect = 1'b0;
        exp_acc = '{32'h0, 32'h4, 32'h8, 32'h300,
                    32'h304, 32'h308, 32'h30C, 32'h310};
        chk("rp accepted count", 32'(acc.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < acc.size())
                chk($sformatf("rp acc[%0d]", i), acc[i], exp_acc[i]);
        end

        // reset pulse mid-stream with PC wrap
        w_en   = '{1, 1, 1, 0, 1, 1, 1};
        w_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4,
                   32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
        w_v    = '{0, 0, 1, 1, 0, 0, 1};
        w_pc   = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC,
                   32'h0, 32'h0, 32'hFFFF_FFF8};
        b1.instr_ready = 1'b1;
        rst1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 7; c++) begin
            rst1 = (c == 3);
            @(negedge clk);
            chk($sformatf("wr c%0d im_en", c), 32'(b1.im_en), 32'(w_en[c]));
            chk($sformatf("wr c%0d im_addr", c), b1.im_addr, w_addr[c]);
            chk($sformatf("wr c%0d valid", c), 32'(b1.instr_valid),
                32'(w_v[c]));
            if (w_v[c]) begin
                chk($sformatf("wr c%0d pc", c), b1.instr_pc, w_pc[c]);
                chk($sformatf("wr c%0d instr", c), b1.instr,
                    w_pc[c] << 1);
            end
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
